// File: rtl/display_regs_pkg.sv
// ============================================================================
// Module   : display_regs_pkg
// Brief    : Register map, control bits and helpers for the display writer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package display_regs_pkg;

    localparam logic [3:0] ADDR_PIPE_X0    = 4'd0;
    localparam logic [3:0] ADDR_BOTTOMTOP0 = 4'd4;
    localparam logic [3:0] ADDR_YSPACE0    = 4'd8;
    localparam logic [3:0] ADDR_BIRD       = 4'd12;
    localparam logic [3:0] ADDR_SCORE      = 4'd13;
    localparam logic [3:0] ADDR_HISCORE    = 4'd14;
    localparam logic [3:0] ADDR_CTRL       = 4'd15;

    localparam int NUM_DATA_REGS = 15;

    localparam int CTRL_COMMIT = 0;
    localparam int CTRL_CLEAR  = 1;

    typedef logic [31:0] reg_word_t;

    function automatic reg_word_t umax(input reg_word_t a, input reg_word_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_edge_detect.sv
// ============================================================================
// Module   : sync_edge_detect
// Brief    : Multi-flop synchronizer followed by a one-clock rising-edge pulse.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], din};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign pulse = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/display_reg_writer.sv
// ============================================================================
// Module   : display_reg_writer
// Brief    : Shadow register bank published atomically to the VGA at frame edge.
// Revision : 1.0
// ============================================================================
`default_nettype none

module display_reg_writer
    import display_regs_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [3:0]             wr_addr,
    input  logic [31:0]            wr_data,
    input  logic [3:0]             rd_addr,
    output logic [31:0]            rd_data,
    input  logic                   screen_end,
    output logic [31:0]            pipe1x,
    output logic [31:0]            pipe2x,
    output logic [31:0]            pipe3x,
    output logic [31:0]            pipe4x,
    output logic [31:0]            pipe1bottomtop,
    output logic [31:0]            pipe2bottomtop,
    output logic [31:0]            pipe3bottomtop,
    output logic [31:0]            pipe4bottomtop,
    output logic [31:0]            pipe1yspace,
    output logic [31:0]            pipe2yspace,
    output logic [31:0]            pipe3yspace,
    output logic [31:0]            pipe4yspace,
    output logic [31:0]            bird_top_left,
    output logic [31:0]            current_score,
    output logic [31:0]            high_score,
    output logic                   frame_tick,
    output logic                   commit_done,
    output logic [FRAME_CNT_W-1:0] frame_count
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ARMED = 1'b1;

    localparam logic [FRAME_CNT_W-1:0] c_frame_one = {{(FRAME_CNT_W-1){1'b0}}, 1'b1};

    reg_word_t              r_shadow [NUM_DATA_REGS];
    reg_word_t              r_live   [NUM_DATA_REGS];
    logic [0:0]             r_state;
    logic                   r_clear_pending;
    logic                   r_frame_tick;
    logic                   r_commit_done;
    logic [FRAME_CNT_W-1:0] r_frame_count;

    logic      w_fe;
    logic      w_pending;
    logic      w_ctrl_wr;
    logic      w_commit;
    logic      w_clear;
    logic      w_data_wr;
    logic      w_apply;
    reg_word_t w_hiscore;

    sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .din  (screen_end),
        .pulse(w_fe)
    );

    assign w_pending = (r_state == ST_ARMED);
    assign w_ctrl_wr = wr_en && (wr_addr == ADDR_CTRL);
    assign w_commit  = w_ctrl_wr && (wr_data[CTRL_COMMIT] || wr_data[CTRL_CLEAR]);
    assign w_clear   = w_ctrl_wr && wr_data[CTRL_CLEAR];
    assign w_data_wr = wr_en && (wr_addr != ADDR_CTRL);
    // A commit landing on the same edge as fe is not applied by that fe.
    assign w_apply   = w_fe && w_pending;
    assign w_hiscore = umax(r_shadow[ADDR_HISCORE], r_shadow[ADDR_SCORE]);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state         <= ST_IDLE;
            r_clear_pending <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE:  if (w_commit) r_state <= ST_ARMED;
                ST_ARMED: if (w_fe && !w_commit) r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
            if (w_clear) begin
                r_clear_pending <= 1'b1;
            end else if (w_fe) begin
                r_clear_pending <= 1'b0;
            end
        end
    end

    // Copy reads pre-edge shadow; a same-cycle processor write overrides it afterwards.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_DATA_REGS; i++) begin
                r_shadow[i] <= '0;
                r_live[i]   <= '0;
            end
        end else begin
            if (w_apply) begin
                for (int i = 0; i < NUM_DATA_REGS - 1; i++) begin
                    r_live[i] <= r_clear_pending ? '0 : r_shadow[i];
                    if (r_clear_pending) begin
                        r_shadow[i] <= '0;
                    end
                end
                r_live[ADDR_HISCORE]   <= w_hiscore;
                r_shadow[ADDR_HISCORE] <= w_hiscore;
            end
            if (w_data_wr) begin
                r_shadow[wr_addr] <= wr_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_frame_tick  <= 1'b0;
            r_commit_done <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_frame_tick  <= w_fe;
            r_commit_done <= w_apply;
            if (w_fe) begin
                r_frame_count <= r_frame_count + c_frame_one;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        if (rd_addr == ADDR_CTRL) begin
            rd_data = {29'b0, r_clear_pending, w_pending, r_frame_count[0]};
        end else begin
            rd_data = r_shadow[rd_addr];
        end
    end

    assign pipe1x         = r_live[ADDR_PIPE_X0];
    assign pipe2x         = r_live[ADDR_PIPE_X0 + 4'd1];
    assign pipe3x         = r_live[ADDR_PIPE_X0 + 4'd2];
    assign pipe4x         = r_live[ADDR_PIPE_X0 + 4'd3];
    assign pipe1bottomtop = r_live[ADDR_BOTTOMTOP0];
    assign pipe2bottomtop = r_live[ADDR_BOTTOMTOP0 + 4'd1];
    assign pipe3bottomtop = r_live[ADDR_BOTTOMTOP0 + 4'd2];
    assign pipe4bottomtop = r_live[ADDR_BOTTOMTOP0 + 4'd3];
    assign pipe1yspace    = r_live[ADDR_YSPACE0];
    assign pipe2yspace    = r_live[ADDR_YSPACE0 + 4'd1];
    assign pipe3yspace    = r_live[ADDR_YSPACE0 + 4'd2];
    assign pipe4yspace    = r_live[ADDR_YSPACE0 + 4'd3];
    assign bird_top_left  = r_live[ADDR_BIRD];
    assign current_score  = r_live[ADDR_SCORE];
    assign high_score     = r_live[ADDR_HISCORE];
    assign frame_tick     = r_frame_tick;
    assign commit_done    = r_commit_done;
    assign frame_count    = r_frame_count;

endmodule

`default_nettype wire

// File: tb/tb_display_reg_writer.sv
// ============================================================================
// Module   : tb_display_reg_writer
// Brief    : Directed + random checking of display_reg_writer against a reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_display_reg_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  rd_addr;
    logic [31:0] rd_data;
    logic        screen_end;
    logic [31:0] pipe1x, pipe2x, pipe3x, pipe4x;
    logic [31:0] pipe1bottomtop, pipe2bottomtop, pipe3bottomtop, pipe4bottomtop;
    logic [31:0] pipe1yspace, pipe2yspace, pipe3yspace, pipe4yspace;
    logic [31:0] bird_top_left, current_score, high_score;
    logic        frame_tick, commit_done;
    logic [15:0] frame_count;

    logic [31:0] live_out [15];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [31:0] m_sh [15];
    logic [31:0] m_lv [15];
    logic        m_pend, m_clr, m_tick, m_done;
    logic [15:0] m_fc;
    logic        s1, s2, s3;

    always #5 clk = ~clk;

    display_reg_writer dut (
        .clk           (clk),
        .reset         (reset),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .screen_end    (screen_end),
        .pipe1x        (pipe1x),
        .pipe2x        (pipe2x),
        .pipe3x        (pipe3x),
        .pipe4x        (pipe4x),
        .pipe1bottomtop(pipe1bottomtop),
        .pipe2bottomtop(pipe2bottomtop),
        .pipe3bottomtop(pipe3bottomtop),
        .pipe4bottomtop(pipe4bottomtop),
        .pipe1yspace   (pipe1yspace),
        .pipe2yspace   (pipe2yspace),
        .pipe3yspace   (pipe3yspace),
        .pipe4yspace   (pipe4yspace),
        .bird_top_left (bird_top_left),
        .current_score (current_score),
        .high_score    (high_score),
        .frame_tick    (frame_tick),
        .commit_done   (commit_done),
        .frame_count   (frame_count)
    );

    assign live_out[0]  = pipe1x;
    assign live_out[1]  = pipe2x;
    assign live_out[2]  = pipe3x;
    assign live_out[3]  = pipe4x;
    assign live_out[4]  = pipe1bottomtop;
    assign live_out[5]  = pipe2bottomtop;
    assign live_out[6]  = pipe3bottomtop;
    assign live_out[7]  = pipe4bottomtop;
    assign live_out[8]  = pipe1yspace;
    assign live_out[9]  = pipe2yspace;
    assign live_out[10] = pipe3yspace;
    assign live_out[11] = pipe4yspace;
    assign live_out[12] = bird_top_left;
    assign live_out[13] = current_score;
    assign live_out[14] = high_score;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 15; i++) begin
            m_sh[i] = '0;
            m_lv[i] = '0;
        end
        m_pend = 1'b0; m_clr = 1'b0; m_tick = 1'b0; m_done = 1'b0;
        m_fc = '0; s1 = 1'b0; s2 = 1'b0; s3 = 1'b0;
    endtask

    function automatic logic [31:0] model_rd(input logic [3:0] a);
        if (a == 4'd15) return {29'b0, m_clr, m_pend, m_fc[0]};
        return m_sh[a];
    endfunction

    // Frame boundary is seen SYNC_STAGES+1 = 3 edges after screen_end is first sampled high.
    task automatic model_edge();
        logic [31:0] old_sh [15];
        logic        fe;
        logic [31:0] hs;
        logic        is_ctrl;
        if (!reset) begin
            model_reset();
            return;
        end
        fe = s2 & ~s3;
        s3 = s2; s2 = s1; s1 = screen_end;
        old_sh = m_sh;
        m_tick = fe;
        m_done = fe && m_pend;
        if (fe) m_fc = m_fc + 16'd1;
        if (fe && m_pend) begin
            hs = (old_sh[14] > old_sh[13]) ? old_sh[14] : old_sh[13];
            for (int i = 0; i < 14; i++) begin
                m_lv[i] = m_clr ? 32'd0 : old_sh[i];
                if (m_clr) m_sh[i] = 32'd0;
            end
            m_lv[14] = hs;
            m_sh[14] = hs;
        end
        is_ctrl = wr_en && (wr_addr == 4'd15);
        m_pend = (is_ctrl && (wr_data[1:0] != 2'b00)) || (m_pend && !fe);
        m_clr  = (is_ctrl && wr_data[1]) || (m_clr && !fe);
        if (wr_en && wr_addr != 4'd15) m_sh[wr_addr] = wr_data;
    endtask

    task automatic check_outputs();
        for (int i = 0; i < 15; i++) check($sformatf("live%0d", i), live_out[i], m_lv[i]);
        check("frame_tick", {31'b0, frame_tick}, {31'b0, m_tick});
        check("commit_done", {31'b0, commit_done}, {31'b0, m_done});
        check("frame_count", {16'b0, frame_count}, {16'b0, m_fc});
        check($sformatf("rd_data[%0d]", rd_addr), rd_data, model_rd(rd_addr));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        cycle();
        wr_en = 1'b0;
    endtask

    task automatic frame();
        screen_end = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) screen_end = 1'b0;
            cycle();
            check("fe_latency", {31'b0, frame_tick}, (i == 2) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        int timer;
        int period;
        reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_addr = '0; screen_end = 1'b0;
        model_reset();
        repeat (3) cycle();
        for (int a = 0; a < 16; a++) begin
            rd_addr = a[3:0];
            #1;
            check("rst_rd", rd_data, 32'd0);
        end
        rd_addr = 4'd0;
        cycle();
        reset = 1'b1;
        repeat (3) cycle();

        // Frame counting without commits
        repeat (3) frame();
        check("fc3", {16'b0, frame_count}, 32'd3);
        check("idle_pipe1x", pipe1x, 32'd0);

        // Shadow writes stay hidden until commit
        wr(4'd0, 32'd200);
        wr(4'd12, 32'd150);
        frame();
        check("nocommit_pipe1x", pipe1x, 32'd0);
        rd_addr = 4'd0; #1;
        check("shadow0", rd_data, 32'd200);
        wr(4'd15, 32'd1);
        rd_addr = 4'd15; #1;
        check("status_pend", {31'b0, rd_data[1]}, 32'd1);
        frame();
        check("commit_pipe1x", pipe1x, 32'd200);
        check("commit_bird", bird_top_left, 32'd150);
        rd_addr = 4'd15; #1;
        check("status_after", rd_data & 32'h6, 32'd0);

        // High score max rule
        wr(4'd13, 32'd12); wr(4'd14, 32'd7); wr(4'd15, 32'd1);
        frame();
        check("hs12", high_score, 32'd12);
        check("score12", current_score, 32'd12);
        wr(4'd13, 32'd5); wr(4'd15, 32'd1);
        frame();
        check("hs_keep", high_score, 32'd12);
        check("score5", current_score, 32'd5);

        // Shadow write on the fe cycle
        wr(4'd15, 32'd1);
        screen_end = 1'b1;
        cycle(); cycle();
        wr(4'd0, 32'd300);
        check("race_done", {31'b0, commit_done}, 32'd1);
        check("race_pipe1x", pipe1x, 32'd200);
        rd_addr = 4'd0; #1;
        check("race_shadow", rd_data, 32'd300);
        screen_end = 1'b0;
        repeat (4) cycle();

        // Clear commit
        for (int a = 0; a < 15; a++)
            wr(a[3:0], (a == 14) ? 32'd9 : (a == 13) ? 32'd4 : 32'd1000 + a);
        wr(4'd15, 32'd3);
        frame();
        check("clr_pipe1x", pipe1x, 32'd0);
        check("clr_bird", bird_top_left, 32'd0);
        check("clr_hs", high_score, 32'd9);
        rd_addr = 4'd0; #1;
        check("clr_shadow0", rd_data, 32'd0);

        // Reset while ARMED discards the commit
        wr(4'd0, 32'd77);
        wr(4'd15, 32'd1);
        reset = 1'b0;
        #2;
        check("arst_pipe1x", pipe1x, 32'd0);
        check("arst_hs", high_score, 32'd0);
        check("arst_fc", {16'b0, frame_count}, 32'd0);
        cycle(); cycle();
        reset = 1'b1;
        repeat (3) cycle();
        frame();
        check("postrst_pipe1x", pipe1x, 32'd0);
        check("postrst_hs", high_score, 32'd0);

        // Random traffic with irregular frame pulses and occasional reset
        timer = 0;
        period = 20;
        for (int i = 0; i < 3000; i++) begin
            timer++;
            if (timer >= period) begin
                timer = 0;
                period = $urandom_range(6, 40);
            end
            screen_end = (timer < 4);
            wr_en   = ($urandom_range(0, 1) == 1);
            wr_addr = 4'($urandom_range(0, 15));
            wr_data = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            rd_addr = 4'($urandom_range(0, 15));
            reset   = ($urandom_range(0, 399) != 0);
            cycle();
        end
        reset = 1'b1;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
